// File: rtl/norm1_pkg.sv
// Shared definitions for the RMSNorm sequencer and controller family:
// default datapath widths, FP constants and the sequencer state encoding.
package norm1_pkg;

   localparam int NORM_M     = 8;
   localparam int NORM_K     = 16;
   localparam int NORM_BW_FP = 17;

   // FP word layout: sign, 6-bit exponent (bias 31), 10-bit mantissa
   localparam logic [NORM_BW_FP-1:0] FP_ZERO = 17'h00000;

   typedef logic [3:0] norm1_state_t;

   localparam norm1_state_t ST_IDLE     = 4'd0;
   localparam norm1_state_t ST_P1_RD    = 4'd1;
   localparam norm1_state_t ST_P1_GO    = 4'd2;
   localparam norm1_state_t ST_P1_WAIT  = 4'd3;
   localparam norm1_state_t ST_SUM_GO   = 4'd4;
   localparam norm1_state_t ST_SUM_WAIT = 4'd5;
   localparam norm1_state_t ST_P2_RD    = 4'd6;
   localparam norm1_state_t ST_P2_GO    = 4'd7;
   localparam norm1_state_t ST_P2_WAIT  = 4'd8;
   localparam norm1_state_t ST_P2_WB    = 4'd9;
   localparam norm1_state_t ST_FIN      = 4'd10;

   function automatic logic is_wait_state(input norm1_state_t s);
      is_wait_state = (s == ST_P1_WAIT) || (s == ST_SUM_WAIT) || (s == ST_P2_WAIT);
   endfunction

endpackage

// File: rtl/norm1_wdog.sv
// Watchdog counter: counts enabled cycles from zero and flags expiry on the
// cycle the count reaches LIMIT-1, i.e. after LIMIT enabled cycles.
module norm1_wdog
   import norm1_pkg::*;
#(
   parameter int LIMIT = 32,
   parameter int CW    = $clog2(LIMIT + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   logic [CW-1:0] cnt_r;

   assign expire = en && (cnt_r == CW'(LIMIT - 1));

   // Cycle counter; saturates at the limit until cleared
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= {CW{1'b0}};
      end else if (clr) begin
         cnt_r <= {CW{1'b0}};
      end else if (en && !expire) begin
         cnt_r <= cnt_r + CW'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/norm1_seq.sv
// Tile sequencer for the RMSNorm controller: walks one M-row block in K-wide
// tiles through square/accumulate, rsqrt and scale passes, with SRAM traffic.
module norm1_seq
   import norm1_pkg::*;
#(
   parameter int M     = NORM_M,
   parameter int K     = NORM_K,
   parameter int BW_FP = NORM_BW_FP,
   parameter int AW    = 10,
   parameter int TW    = 6,
   parameter int WDOG  = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   abort,
   input  logic                   state_prefill,
   input  logic                   state_decode,
   input  logic [TW-1:0]          n_tiles,
   input  logic [AW-1:0]          base_in,
   input  logic [AW-1:0]          base_w,
   input  logic [AW-1:0]          base_out,
   input  logic                   busy_norm1,
   input  logic [M*K*BW_FP-1:0]   buffer_norm,
   output logic                   start1,
   output logic                   start1_sum,
   output logic                   start2,
   output logic                   rd_en,
   output logic [AW-1:0]          rd_addr_in,
   output logic [AW-1:0]          rd_addr_w,
   output logic                   wr_en,
   output logic [AW-1:0]          wr_addr,
   output logic [M*K*BW_FP-1:0]   wr_data,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   norm1_state_t  state_r, state_nxt_s;
   logic [TW-1:0] t_r, t_nxt_s, n_tiles_r, n_tiles_nxt_s;
   logic [AW-1:0] base_in_r, base_w_r, base_out_r;
   logic [AW-1:0] base_in_nxt_s, base_w_nxt_s, base_out_nxt_s;
   logic          accept_s, last_s, err_s, wd_en_s, wd_expire_s;
   logic          p1_phase_s, p2_phase_s;

   assign accept_s = start && (state_prefill ^ state_decode) && !abort;
   assign last_s   = (t_r == (n_tiles_r - TW'(1)));
   assign wd_en_s  = is_wait_state(state_r);

   norm1_wdog #(.LIMIT(WDOG)) u_wdog (
      .clk    (clk),
      .rst    (rst),
      .clr    (!wd_en_s),
      .en     (wd_en_s),
      .expire (wd_expire_s)
   );

   // Next-state, tile index and latched-parameter logic
   always_comb begin
      state_nxt_s    = state_r;
      t_nxt_s        = t_r;
      n_tiles_nxt_s  = n_tiles_r;
      base_in_nxt_s  = base_in_r;
      base_w_nxt_s   = base_w_r;
      base_out_nxt_s = base_out_r;
      err_s          = 1'b0;
      if (abort && (state_r != ST_IDLE)) begin
         state_nxt_s = ST_IDLE;
         t_nxt_s     = {TW{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  n_tiles_nxt_s  = n_tiles;
                  base_in_nxt_s  = base_in;
                  base_w_nxt_s   = base_w;
                  base_out_nxt_s = base_out;
                  t_nxt_s        = {TW{1'b0}};
                  state_nxt_s    = (n_tiles == {TW{1'b0}}) ? ST_FIN : ST_P1_RD;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_P1_RD:  state_nxt_s = ST_P1_GO;
            ST_P1_GO:  state_nxt_s = ST_P1_WAIT;
            ST_P1_WAIT: begin
               if (!busy_norm1) begin
                  if (last_s) begin
                     t_nxt_s     = {TW{1'b0}};
                     state_nxt_s = ST_SUM_GO;
                  end else begin
                     t_nxt_s     = t_r + TW'(1);
                     state_nxt_s = ST_P1_RD;
                  end
               end else if (wd_expire_s) begin
                  err_s       = 1'b1;
                  t_nxt_s     = {TW{1'b0}};
                  state_nxt_s = ST_IDLE;
               end else begin
                  state_nxt_s = ST_P1_WAIT;
               end
            end
            ST_SUM_GO: state_nxt_s = ST_SUM_WAIT;
            ST_SUM_WAIT: begin
               if (!busy_norm1) begin
                  state_nxt_s = ST_P2_RD;
               end else if (wd_expire_s) begin
                  err_s       = 1'b1;
                  state_nxt_s = ST_IDLE;
               end else begin
                  state_nxt_s = ST_SUM_WAIT;
               end
            end
            ST_P2_RD:  state_nxt_s = ST_P2_GO;
            ST_P2_GO:  state_nxt_s = ST_P2_WAIT;
            ST_P2_WAIT: begin
               if (!busy_norm1) begin
                  state_nxt_s = ST_P2_WB;
               end else if (wd_expire_s) begin
                  err_s       = 1'b1;
                  t_nxt_s     = {TW{1'b0}};
                  state_nxt_s = ST_IDLE;
               end else begin
                  state_nxt_s = ST_P2_WAIT;
               end
            end
            ST_P2_WB: begin
               if (last_s) begin
                  t_nxt_s     = {TW{1'b0}};
                  state_nxt_s = ST_FIN;
               end else begin
                  t_nxt_s     = t_r + TW'(1);
                  state_nxt_s = ST_P2_RD;
               end
            end
            ST_FIN:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
         endcase
      end
   end

   // Read addresses are held from *_RD through *_WAIT because the controller reads them live
   assign p1_phase_s = (state_nxt_s == ST_P1_RD) || (state_nxt_s == ST_P1_GO) ||
                       (state_nxt_s == ST_P1_WAIT);
   assign p2_phase_s = (state_nxt_s == ST_P2_RD) || (state_nxt_s == ST_P2_GO) ||
                       (state_nxt_s == ST_P2_WAIT);

   // State, latched parameters and registered outputs decoded from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         t_r        <= {TW{1'b0}};
         n_tiles_r  <= {TW{1'b0}};
         base_in_r  <= {AW{1'b0}};
         base_w_r   <= {AW{1'b0}};
         base_out_r <= {AW{1'b0}};
         start1     <= 1'b0;
         start1_sum <= 1'b0;
         start2     <= 1'b0;
         rd_en      <= 1'b0;
         rd_addr_in <= {AW{1'b0}};
         rd_addr_w  <= {AW{1'b0}};
         wr_en      <= 1'b0;
         wr_addr    <= {AW{1'b0}};
         wr_data    <= {(M*K){BW_FP'(FP_ZERO)}};
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         t_r        <= t_nxt_s;
         n_tiles_r  <= n_tiles_nxt_s;
         base_in_r  <= base_in_nxt_s;
         base_w_r   <= base_w_nxt_s;
         base_out_r <= base_out_nxt_s;
         start1     <= (state_nxt_s == ST_P1_GO);
         start1_sum <= (state_nxt_s == ST_SUM_GO);
         start2     <= (state_nxt_s == ST_P2_GO);
         rd_en      <= (state_nxt_s == ST_P1_RD) || (state_nxt_s == ST_P2_RD);
         rd_addr_in <= (p1_phase_s || p2_phase_s) ? (base_in_nxt_s + AW'(t_nxt_s)) : {AW{1'b0}};
         rd_addr_w  <= p1_phase_s ? (base_w_nxt_s + AW'(t_nxt_s)) : {AW{1'b0}};
         wr_en      <= (state_nxt_s == ST_P2_WB);
         wr_addr    <= (state_nxt_s == ST_P2_WB) ? (base_out_nxt_s + AW'(t_nxt_s)) : {AW{1'b0}};
         wr_data    <= (state_nxt_s == ST_P2_WB) ? buffer_norm : {(M*K){BW_FP'(FP_ZERO)}};
         busy       <= (state_nxt_s != ST_IDLE);
         done       <= (state_nxt_s == ST_FIN);
         err        <= err_s;
      end
   end

endmodule

// File: tb/tb_norm1_seq.sv
// Scoreboard bench for norm1_seq: a stub controller with programmable pass
// latency, an event-level reference model and a negedge monitor.
module tb_norm1_seq;

   localparam int M = 8, K = 16, BW_FP = 17, AW = 10, TW = 6, WDOG = 32;
   localparam int DW = M * K * BW_FP;
   localparam int EV_S1 = 1, EV_SUM = 2, EV_S2 = 3, EV_WR = 4, EV_DONE = 5, EV_ERR = 6;

   logic clk, rst, start, abort, state_prefill, state_decode;
   logic [TW-1:0] n_tiles;
   logic [AW-1:0] base_in, base_w, base_out;
   logic busy_norm1;
   logic [DW-1:0] buffer_norm;
   logic start1, start1_sum, start2, rd_en, wr_en, busy, done, err;
   logic [AW-1:0] rd_addr_in, rd_addr_w, wr_addr;
   logic [DW-1:0] wr_data;

   norm1_seq #(.M(M), .K(K), .BW_FP(BW_FP), .AW(AW), .TW(TW), .WDOG(WDOG)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .state_prefill(state_prefill), .state_decode(state_decode),
      .n_tiles(n_tiles), .base_in(base_in), .base_w(base_w), .base_out(base_out),
      .busy_norm1(busy_norm1), .buffer_norm(buffer_norm),
      .start1(start1), .start1_sum(start1_sum), .start2(start2),
      .rd_en(rd_en), .rd_addr_in(rd_addr_in), .rd_addr_w(rd_addr_w),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int            kind;
      logic [AW-1:0] a_in;
      logic [AW-1:0] a_w;
      logic [DW-1:0] data;
   } ev_t;

   ev_t           exp_q[$];
   logic [DW-1:0] stub_data_q[$];
   int n_tests = 0, n_fail = 0;
   int sum_cnt = 0, s2_cnt = 0, done_cnt = 0, err_cnt = 0;
   int lat1 = 3, lat_s = 3, lat2 = 3;
   bit stuck = 1'b0, stub_flush = 1'b0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] r;
      for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Reference model: the event stream one block should produce
   task automatic expect_block(input int n, input logic [AW-1:0] bi, input logic [AW-1:0] bw,
                               input logic [AW-1:0] bo);
      ev_t e;
      for (int t = 0; t < n; t++) begin
         e.kind = EV_S1; e.a_in = bi + AW'(t); e.a_w = bw + AW'(t); e.data = '0;
         exp_q.push_back(e);
      end
      if (n > 0) begin
         e.kind = EV_SUM; e.a_in = '0; e.a_w = '0; e.data = '0;
         exp_q.push_back(e);
         for (int t = 0; t < n; t++) begin
            e.kind = EV_S2; e.a_in = bi + AW'(t); e.a_w = '0; e.data = '0;
            exp_q.push_back(e);
            e.kind = EV_WR; e.a_in = bo + AW'(t); e.a_w = '0; e.data = rand_data();
            stub_data_q.push_back(e.data);
            exp_q.push_back(e);
         end
      end
      e.kind = EV_DONE; e.a_in = '0; e.a_w = '0; e.data = '0;
      exp_q.push_back(e);
   endtask

   // Stub controller: busy rises the edge after a start pulse, held lat cycles
   initial begin
      int rem, lat;
      logic k1, ks, k2;
      busy_norm1 = 1'b0; buffer_norm = '0; rem = 0;
      forever begin
         @(negedge clk);
         k1 = start1; ks = start1_sum; k2 = start2;
         @(posedge clk); #1;
         if (stub_flush) begin
            busy_norm1 = 1'b0; rem = 0;
         end else if (k1 || ks || k2) begin
            lat = k1 ? lat1 : (ks ? lat_s : lat2);
            if (k2 && stub_data_q.size() > 0) buffer_norm = stub_data_q.pop_front();
            if (stuck) begin busy_norm1 = 1'b1; rem = -1; end
            else if (lat > 0) begin busy_norm1 = 1'b1; rem = lat; end
         end else if (rem > 0) begin
            rem--;
            if (rem == 0) busy_norm1 = 1'b0;
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT presents a pulse
   initial begin
      int np, kind;
      logic prev_rd_en;
      logic [AW-1:0] prev_in, prev_w;
      ev_t e;
      prev_rd_en = 1'b0; prev_in = '0; prev_w = '0;
      forever begin
         @(negedge clk);
         np = int'(start1) + int'(start1_sum) + int'(start2) + int'(wr_en) + int'(done) + int'(err);
         if (np != 0) begin
            kind = start1 ? EV_S1 : start1_sum ? EV_SUM : start2 ? EV_S2 :
                   wr_en ? EV_WR : done ? EV_DONE : EV_ERR;
            check("single_pulse", np, 1);
            if (start1 || start1_sum || start2) check("start_while_ctrl_busy", busy_norm1, 0);
            if (start1_sum) sum_cnt++;
            if (start2) s2_cnt++;
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (exp_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_pulse: got kind %0d expected none", kind);
            end else begin
               e = exp_q.pop_front();
               check("event_kind", kind, e.kind);
               if (kind == EV_S1 || kind == EV_S2) begin
                  check("go_addr_in", rd_addr_in, e.a_in);
                  check("go_addr_w", rd_addr_w, e.a_w);
                  check("rd_en_before_go", prev_rd_en, 1);
                  check("addr_in_stable", rd_addr_in, prev_in);
               end
               if (kind == EV_WR) begin
                  check("wr_addr", wr_addr, e.a_in);
                  n_tests++;
                  if (wr_data !== e.data) begin
                     n_fail++;
                     $display("FAIL wr_data: got low word %08h expected %08h",
                              wr_data[31:0], e.data[31:0]);
                  end
               end
            end
         end
         prev_rd_en = rd_en; prev_in = rd_addr_in; prev_w = rd_addr_w;
      end
   end

   task automatic issue_start(input int n, input logic [AW-1:0] bi, input logic [AW-1:0] bw,
                              input logic [AW-1:0] bo, input bit pf, input bit dc);
      n_tiles = n[TW-1:0]; base_in = bi; base_w = bw; base_out = bo;
      state_prefill = pf; state_decode = dc; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int d0, input string tag);
      int k;
      k = 0;
      while (done_cnt == d0 && k < 3000) begin @(posedge clk); #1; k++; end
      check({tag, "_done_count"}, done_cnt - d0, 1);
      repeat (2) @(posedge clk); #1;
      check({tag, "_queue_drained"}, exp_q.size(), 0);
      check({tag, "_idle"}, busy, 0);
      exp_q.delete(); stub_data_q.delete();
   endtask

   task automatic run_block(input int n, input logic [AW-1:0] bi, input logic [AW-1:0] bw,
                            input logic [AW-1:0] bo, input bit pf, input string tag);
      int d0;
      d0 = done_cnt;
      expect_block(n, bi, bw, bo);
      issue_start(n, bi, bw, bo, pf, !pf);
      wait_done(d0, tag);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ctrl_zero"}, {start1, start1_sum, start2, rd_en, wr_en, busy, done, err}, 8'h00);
      check({tag, "_addr_zero"}, {rd_addr_in, rd_addr_w, wr_addr}, 30'h0);
      check({tag, "_wdata_zero"}, (wr_data == '0), 1);
   endtask

   task automatic flush_stub();
      stub_flush = 1'b1;
      repeat (2) @(posedge clk); #1;
      stub_flush = 1'b0;
      exp_q.delete(); stub_data_q.delete();
   endtask

   initial begin
      int d0, e0, k, s0;
      ev_t e;
      rst = 1'b1; start = 1'b0; abort = 1'b0; state_prefill = 1'b0; state_decode = 1'b0;
      n_tiles = '0; base_in = '0; base_w = '0; base_out = '0;
      repeat (3) @(posedge clk); #1;
      check_all_zero("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      lat1 = 19; lat_s = 6; lat2 = 4;
      run_block(2, 10'h100, 10'h040, 10'h200, 1'b1, "example");

      // Empty block: FIN straight from IDLE
      d0 = done_cnt;
      expect_block(0, 10'h000, 10'h000, 10'h000);
      issue_start(0, 10'h055, 10'h066, 10'h077, 1'b0, 1'b1);
      check("n0_done_next_cycle", done, 1);
      @(posedge clk); #1;
      check("n0_done_single", done, 0);
      check("n0_busy_clear", busy, 0);
      wait_done(d0, "n0");

      // Watchdog: controller never finishes phase 1
      stuck = 1'b1; d0 = done_cnt; e0 = err_cnt;
      e.kind = EV_S1; e.a_in = 10'h010; e.a_w = 10'h020; e.data = '0; exp_q.push_back(e);
      e.kind = EV_ERR; e.a_in = '0; e.a_w = '0; exp_q.push_back(e);
      issue_start(3, 10'h010, 10'h020, 10'h030, 1'b1, 1'b0);
      k = 1;
      while (!err && k < 100) begin @(posedge clk); #1; k++; end
      // start sampled ending cycle 0; P1_WAIT entered at cycle 3, err WDOG cycles later
      check("wdog_latency", k, 3 + WDOG);
      @(posedge clk); #1;
      check("wdog_err_single", err, 0);
      check("wdog_busy_low", busy, 0);
      repeat (3) @(posedge clk); #1;
      check("wdog_no_done", done_cnt - d0, 0);
      check("wdog_err_count", err_cnt - e0, 1);
      check("wdog_queue_drained", exp_q.size(), 0);
      stuck = 1'b0;
      flush_stub();

      // Abort while waiting on rsqrt
      lat1 = 3; lat_s = 10; lat2 = 3; d0 = done_cnt; s0 = sum_cnt;
      expect_block(2, 10'h0A0, 10'h0B0, 10'h0C0);
      issue_start(2, 10'h0A0, 10'h0B0, 10'h0C0, 1'b1, 1'b0);
      k = 0;
      while (sum_cnt == s0 && k < 500) begin @(posedge clk); #1; k++; end
      check("abort_reached_sum", sum_cnt - s0, 1);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check_all_zero("abort");
      exp_q.delete(); stub_data_q.delete();
      repeat (15) @(posedge clk); #1;
      check("abort_no_done", done_cnt - d0, 0);
      run_block(3, 10'h1F0, 10'h2F0, 10'h3F0, 1'b0, "after_abort");

      // Ignored starts: bad mode bits, abort+start, and start during a run
      issue_start(2, 10'h111, 10'h111, 10'h111, 1'b1, 1'b1);
      check("both_modes_ignored", busy, 0);
      issue_start(2, 10'h111, 10'h111, 10'h111, 1'b0, 1'b0);
      check("no_mode_ignored", busy, 0);
      abort = 1'b1;
      issue_start(2, 10'h111, 10'h111, 10'h111, 1'b1, 1'b0);
      abort = 1'b0;
      check("abort_beats_start", busy, 0);
      d0 = done_cnt;
      expect_block(2, 10'h080, 10'h0C0, 10'h180);
      issue_start(2, 10'h080, 10'h0C0, 10'h180, 1'b1, 1'b0);
      repeat (5) @(posedge clk); #1;
      issue_start(5, 10'h3A0, 10'h111, 10'h222, 1'b1, 1'b0);
      wait_done(d0, "restart_ignored");

      // Synchronous reset during phase 2 wait
      lat2 = 8; d0 = done_cnt; s0 = s2_cnt;
      expect_block(2, 10'h300, 10'h301, 10'h302);
      issue_start(2, 10'h300, 10'h301, 10'h302, 1'b0, 1'b1);
      k = 0;
      while (s2_cnt == s0 && k < 500) begin @(posedge clk); #1; k++; end
      check("rst_reached_p2", s2_cnt - s0, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_all_zero("midrun_reset");
      flush_stub();
      repeat (10) @(posedge clk); #1;
      check("midrun_reset_no_done", done_cnt - d0, 0);
      run_block(2, 10'h3FF, 10'h3FE, 10'h3FF, 1'b0, "wrap");

      // Randomised blocks including zero-latency controller passes
      for (int i = 0; i < 12; i++) begin
         lat1 = $urandom_range(0, 20); lat_s = $urandom_range(0, 20); lat2 = $urandom_range(0, 20);
         run_block($urandom_range(1, 5), AW'($urandom), AW'($urandom), AW'($urandom),
                   1'($urandom_range(0, 1)), "random");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/norm1_seq.md
Name: norm1_seq

Overview:
- Tile sequencer that sits directly upstream of the RMSNorm datapath controller (norm1_ctrl).
- For one M-row block, it walks the hidden dimension in K-wide column tiles:
  - issues the phase-1 square/accumulate pulse per tile;
  - issues one rsqrt (sum) pulse;
  - issues the phase-2 scale pulse per tile.
- Drives the SRAM read address feeding Input/W_norm1 and writes the normalised tile (buffer_norm) back to SRAM.

Parameters:
- M, 8, rows per block
- K, 16, columns per tile
- BW_FP, 17, FP word width
- AW, 10, SRAM address width
- TW, 6, tile-count width
- WDOG, 32, watchdog limit in cycles for one controller pass

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle request to normalise one block
- abort  in  1  one-cycle cancel
- state_prefill  in  1  prefill mode, passed through to controller
- state_decode  in  1  decode mode, passed through
- n_tiles  in  TW  tiles per block, sampled on start
- base_in  in  AW  activation SRAM base, sampled on start
- base_w  in  AW  weight SRAM base, sampled on start
- base_out  in  AW  result SRAM base, sampled on start
- busy_norm1  in  1  controller busy
- buffer_norm  in  M*K*BW_FP  controller result
- start1  out  1  phase-1 pulse
- start1_sum  out  1  rsqrt pulse
- start2  out  1  phase-2 pulse
- rd_en  out  1  activation/weight read enable
- rd_addr_in  out  AW  activation address
- rd_addr_w  out  AW  weight address
- wr_en  out  1  result write enable
- wr_addr  out  AW  result address
- wr_data  out  M*K*BW_FP  result data
- busy  out  1  sequencer active
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle watchdog pulse

Behaviour:
- Reset (rst=1 at a clock edge): all outputs 0, FSM to IDLE, tile counter t=0, watchdog counter 0. This applies mid-operation too; no pulse completes after reset.
- FSM states: IDLE, P1_RD, P1_GO, P1_WAIT, SUM_GO, SUM_WAIT, P2_RD, P2_GO, P2_WAIT, P2_WB, FIN.
- IDLE:
  - start=1 with exactly one of state_prefill/state_decode set: latch n_tiles and the three bases, set t=0, go to P1_RD. busy=1 from the next cycle.
  - start with neither or both mode bits set is ignored.
  - start while busy=1 is ignored.
- n_tiles==0: IDLE -> FIN; done is asserted one cycle after start; no start* pulse or write occurs.
- P1_RD:
  - rd_en=1, rd_addr_in=base_in+t, rd_addr_w=base_w+t. SRAM latency is 1 cycle.
  - Both addresses stay stable through P1_GO and P1_WAIT, because the controller samples Input combinationally for the whole pass.
  - Next state P1_GO.
- P1_GO: start1=1 for exactly one cycle -> P1_WAIT.
- P1_WAIT:
  - Entered the cycle busy_norm1 rises.
  - Stay while busy_norm1=1.
  - On busy_norm1=0: t++. If t==n_tiles-1, go to SUM_GO with t cleared to 0; otherwise go to P1_RD.
- SUM_GO: start1_sum=1 for one cycle -> SUM_WAIT. SUM_WAIT exits on busy_norm1=0 to P2_RD.
- P2_RD / P2_GO / P2_WAIT: same as P1 with start2; rd_addr_w is don't-care and driven 0.
- P2_WAIT: exits on busy_norm1=0 to P2_WB.
- P2_WB:
  - wr_en=1, wr_addr=base_out+t, wr_data=buffer_norm for one cycle.
  - If t==n_tiles-1 go to FIN, else t++ and go to P2_RD.
- FIN: done=1 for one cycle, busy=0 next cycle, -> IDLE.
- Start pulses: never two start* pulses in the same cycle; never a start* pulse while busy_norm1=1.
- Address arithmetic: modulo 2^AW; wrap-around is permitted silently.
- Watchdog:
  - Counts cycles in any *_WAIT state; cleared on state exit.
  - If it reaches WDOG: err=1 for one cycle, go to IDLE, no done.
  - Also, if busy_norm1 is still 0 one cycle after a GO state, the watchdog still runs and the WAIT state exits immediately. This is legal: the controller may finish trivially.
- abort:
  - Any non-IDLE state -> IDLE next cycle; all outputs 0; no done, no err.
  - Abort in the same cycle as wr_en suppresses nothing already registered.
  - abort together with start in IDLE: abort wins.

Decomposition:
- Package norm1_pkg holds:
  - FSM state enum typedef;
  - default widths M, K, BW_FP;
  - shared FP constants used by the norm controllers.
- One natural sub-module: norm1_wdog (loadable up-counter with clear/expire), reusable by the norm2 path.

Test Plan:
- Stub controller holding busy for 19/6/4 cycles per pass; n_tiles=2, base_in=0x100, base_w=0x040, base_out=0x200 -> expected sequence:
  - start1 twice, with rd_addr_in 0x100 then 0x101;
  - one start1_sum;
  - start2 twice;
  - writes to 0x200 and 0x201 carrying stub buffer_norm;
  - a single done.
- n_tiles=0 -> done exactly 1 cycle after start, zero start*/wr_en pulses.
- Stub never drops busy after start1 -> err pulse 32 cycles after entering P1_WAIT, busy=0 next cycle, no done.
- abort asserted in SUM_WAIT -> all outputs 0 next cycle; a fresh start then completes normally.
- start with state_prefill=state_decode=1, then start during a run -> both ignored; t and latched bases unchanged.
- rst=1 in P2_WAIT -> all outputs 0 next cycle; base_out=0x3FF with n_tiles=2 -> second write to 0x000 (wrap).
